// File: rtl/snowbro2_cen_ctrl_if.sv
// -----------------------------------------------------------------------------
// snowbro2_cen_ctrl_if
//
// Bundles the strobe and status signals between a fractional clock-enable
// source, the recovery controller and its consumer.
//
// Signals:
//   cen_in   raw single-cycle enable strobe from the fractional divider
//   stall    consumer is waiting on memory; no strobe may be delivered
//   pause    level-sensitive freeze request
//   cen_out  registered single-cycle enable to the consumer
//   credit   number of banked strobes (CW bits)
//   catchup  high while banked strobes are being replayed
//   lost     saturating count of strobes dropped on a full bank
//
// Modports:
//   master   source/consumer side (drives cen_in, stall, pause)
//   slave    controller side (drives cen_out, credit, catchup, lost)
// -----------------------------------------------------------------------------
interface snowbro2_cen_ctrl_if #(
    parameter int CW = 4
);
    logic          cen_in;
    logic          stall;
    logic          pause;
    logic          cen_out;
    logic [CW-1:0] credit;
    logic          catchup;
    logic [7:0]    lost;

    modport master (
        output cen_in,
        output stall,
        output pause,
        input  cen_out,
        input  credit,
        input  catchup,
        input  lost
    );

    modport slave (
        input  cen_in,
        input  stall,
        input  pause,
        output cen_out,
        output credit,
        output catchup,
        output lost
    );
endinterface

// File: rtl/snowbro2_cen_ctrl.sv
// -----------------------------------------------------------------------------
// snowbro2_cen_ctrl
//
// Clock-enable recovery controller. Raw strobes that cannot be delivered
// (consumer stalled on SDRAM, or too close to the previous output pulse) are
// banked as credits and replayed later at no more than one pulse per GAP
// cycles, so the consumer's long-run strobe count tracks the source. A pause
// request freezes delivery while keeping the banked credits.
//
// Parameters:
//   CW   credit counter width; bank holds up to 2^CW-1 strobes (CW >= 1)
//   GAP  minimum spacing in clk cycles between cen_out pulses (1..15)
//
// Ports:
//   clk    domain clock, all logic on the rising edge
//   reset  synchronous active-high reset
//   bus    slave side of snowbro2_cen_ctrl_if
//            in : cen_in, stall, pause
//            out: cen_out, credit, catchup, lost (all registered)
// -----------------------------------------------------------------------------
module snowbro2_cen_ctrl #(
    parameter int CW  = 4,
    parameter int GAP = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    snowbro2_cen_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_CATCHUP = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CREDIT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CREDIT_ZERO = {CW{1'b0}};
    localparam logic [3:0]    GAP_V       = 4'(GAP);

    // Saturating increment of the 8-bit lost-strobe counter.
    function automatic logic [7:0] lost_sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // Spacing counter advance: restart at 1 on a delivered pulse, otherwise
    // count up and hold at GAP so "eligible" is a simple compare.
    function automatic logic [3:0] gap_next(input logic [3:0] value,
                                            input logic       fire);
        logic [3:0] result;
        if (fire) begin
            result = 4'd1;
        end else if (value < GAP_V) begin
            result = value + 4'd1;
        end else begin
            result = GAP_V;
        end
        return result;
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] credit_r;
    logic [CW-1:0] credit_s;
    logic [7:0]    lost_r;
    logic [7:0]    lost_s;
    logic [3:0]    gap_cnt_r;
    logic [3:0]    gap_cnt_s;
    logic          cen_out_r;
    logic          catchup_r;
    logic          fire_s;
    logic          eligible_s;

    // Spacing check: gap_cnt_r is the number of cycles since the last
    // delivery decision, so a decision now yields a pulse at least GAP
    // cycles after the previous pulse.
    always_comb begin
        eligible_s = (gap_cnt_r >= GAP_V);
    end

    // Next-state, credit, lost-counter and delivery decision.
    always_comb begin
        state_s   = state_r;
        credit_s  = credit_r;
        lost_s    = lost_r;
        fire_s    = 1'b0;

        case (state_r)
            ST_RUN, ST_CATCHUP: begin
                if (bus.pause) begin
                    // Strobe arriving with the pause request is discarded.
                    state_s = ST_PAUSED;
                end else begin
                    if (bus.stall || !eligible_s) begin
                        // Cannot deliver now: bank the strobe if room remains.
                        if (bus.cen_in) begin
                            if (credit_r != CREDIT_MAX) begin
                                credit_s = credit_r + CW'(1'b1);
                            end else begin
                                lost_s = lost_sat_inc(lost_r);
                            end
                        end else begin
                            credit_s = credit_r;
                        end
                    end else if (bus.cen_in) begin
                        // Live strobe wins over a replay; credit untouched.
                        fire_s = 1'b1;
                    end else if (credit_r != CREDIT_ZERO) begin
                        fire_s   = 1'b1;
                        credit_s = credit_r - CW'(1'b1);
                    end else begin
                        fire_s = 1'b0;
                    end

                    if (credit_s != CREDIT_ZERO) begin
                        state_s = ST_CATCHUP;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end

            ST_PAUSED: begin
                // No accrual, no loss and no delivery while frozen; the
                // resume cycle itself only changes state.
                if (!bus.pause) begin
                    if (credit_r != CREDIT_ZERO) begin
                        state_s = ST_CATCHUP;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_PAUSED;
                end
            end

            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // Spacing counter keeps running in every state, including PAUSED.
    always_comb begin
        gap_cnt_s = gap_next(gap_cnt_r, fire_s);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_RUN;
            credit_r  <= CREDIT_ZERO;
            lost_r    <= 8'd0;
            gap_cnt_r <= GAP_V;
            cen_out_r <= 1'b0;
            catchup_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            credit_r  <= credit_s;
            lost_r    <= lost_s;
            gap_cnt_r <= gap_cnt_s;
            cen_out_r <= fire_s;
            catchup_r <= (state_s == ST_CATCHUP);
        end
    end

    // Drive the interface outputs straight from registers.
    always_comb begin
        bus.cen_out = cen_out_r;
        bus.credit  = credit_r;
        bus.catchup = catchup_r;
        bus.lost    = lost_r;
    end

endmodule

// File: tb/tb_snowbro2_cen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snowbro2_cen_ctrl
//
// Directed bench for snowbro2_cen_ctrl with CW=4, GAP=3. Inputs are driven
// and outputs sampled on the falling edge; after one tick the outputs show
// the result of the rising edge that consumed the inputs just applied.
// -----------------------------------------------------------------------------
module tb_snowbro2_cen_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   pulse_cnt;

    snowbro2_cen_ctrl_if #(.CW(4)) bus ();

    snowbro2_cen_ctrl #(
        .CW  (4),
        .GAP (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; tally delivered pulses.
    task automatic tick();
        @(negedge clk);
        if (bus.cen_out === 1'b1) pulse_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cen_in = 1'b0;
        bus.stall = 1'b0;
        bus.pause = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus.cen_out !== 1'b0 || bus.credit !== 4'd0 || bus.catchup !== 1'b0 || bus.lost !== 8'd0) begin
            n_err++;
            $display("FAIL reset: cen_out=%b credit=%0d catchup=%b lost=%0d expected 0/0/0/0",
                     bus.cen_out, bus.credit, bus.catchup, bus.lost);
        end
        reset = 1'b0;
    endtask

    task automatic test_pass_through();
        logic exp;
        for (int i = 0; i < 35; i++) begin
            exp = (i % 7 == 0);
            bus.cen_in = exp;
            tick();
            n_vec++;
            if (bus.cen_out !== exp || bus.credit !== 4'd0 || bus.catchup !== 1'b0) begin
                n_err++;
                $display("FAIL passthru cyc %0d: cen_out=%b credit=%0d catchup=%b expected %b/0/0",
                         i, bus.cen_out, bus.credit, bus.catchup, exp);
            end
        end
        bus.cen_in = 1'b0;
    endtask

    task automatic test_stall_replay();
        logic [39:0] mask;
        bus.stall = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.cen_in = (i % 6 == 0);
            tick();
            n_vec++;
            if (bus.cen_out !== 1'b0) begin
                n_err++;
                $display("FAIL stall_block cyc %0d: cen_out=%b expected 0", i, bus.cen_out);
            end
        end
        n_vec++;
        if (bus.credit !== 4'd5 || bus.catchup !== 1'b1) begin
            n_err++;
            $display("FAIL stall_bank: credit=%0d catchup=%b expected 5/1", bus.credit, bus.catchup);
        end
        // Replays every 3 cycles; live strobes at 3,24,31,38 go straight
        // through, those at 10 and 17 land too close and are banked.
        mask = '0;
        mask[0] = 1'b1;  mask[3] = 1'b1;  mask[6] = 1'b1;  mask[9] = 1'b1;
        mask[12] = 1'b1; mask[15] = 1'b1; mask[18] = 1'b1; mask[21] = 1'b1;
        mask[24] = 1'b1; mask[31] = 1'b1; mask[38] = 1'b1;
        bus.stall = 1'b0;
        for (int j = 0; j < 40; j++) begin
            bus.cen_in = (j % 7 == 3);
            tick();
            n_vec++;
            if (bus.cen_out !== mask[j]) begin
                n_err++;
                $display("FAIL replay cyc %0d: cen_out=%b expected %b", j, bus.cen_out, mask[j]);
            end
            if (j == 10) begin
                n_vec++;
                if (bus.credit !== 4'd3) begin
                    n_err++;
                    $display("FAIL replay_rebank: credit=%0d expected 3", bus.credit);
                end
            end
            if (j == 20) begin
                n_vec++;
                if (bus.credit !== 4'd1 || bus.catchup !== 1'b1) begin
                    n_err++;
                    $display("FAIL replay_last: credit=%0d catchup=%b expected 1/1", bus.credit, bus.catchup);
                end
            end
        end
        bus.cen_in = 1'b0;
        n_vec++;
        if (bus.credit !== 4'd0 || bus.catchup !== 1'b0) begin
            n_err++;
            $display("FAIL replay_drain: credit=%0d catchup=%b expected 0/0", bus.credit, bus.catchup);
        end
    endtask

    task automatic test_saturation();
        bus.stall = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.cen_in = (i % 3 == 0);
            tick();
        end
        n_vec++;
        if (bus.credit !== 4'd15 || bus.lost !== 8'd5 || bus.catchup !== 1'b1) begin
            n_err++;
            $display("FAIL sat_bank: credit=%0d lost=%0d catchup=%b expected 15/5/1",
                     bus.credit, bus.lost, bus.catchup);
        end
        bus.stall = 1'b0;
        pulse_cnt = 0;
        for (int j = 0; j < 80; j++) begin
            bus.cen_in = (j % 10 == 5);
            tick();
        end
        bus.cen_in = 1'b0;
        n_vec++;
        if (pulse_cnt != 23) begin
            n_err++;
            $display("FAIL sat_total: pulses=%0d expected 23", pulse_cnt);
        end
        n_vec++;
        if (bus.credit !== 4'd0 || bus.lost !== 8'd5 || bus.catchup !== 1'b0) begin
            n_err++;
            $display("FAIL sat_drain: credit=%0d lost=%0d catchup=%b expected 0/5/0",
                     bus.credit, bus.lost, bus.catchup);
        end
    endtask

    task automatic test_pause();
        logic [24:0] mask;
        bus.stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.cen_in = (i % 4 == 0);
            tick();
        end
        n_vec++;
        if (bus.credit !== 4'd4 || bus.catchup !== 1'b1) begin
            n_err++;
            $display("FAIL pause_setup: credit=%0d catchup=%b expected 4/1", bus.credit, bus.catchup);
        end
        bus.stall = 1'b0;
        bus.pause = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.cen_in = (i % 7 == 0);
            tick();
            n_vec++;
            if (bus.cen_out !== 1'b0 || bus.credit !== 4'd4 || bus.lost !== 8'd5 || bus.catchup !== 1'b0) begin
                n_err++;
                $display("FAIL paused cyc %0d: cen_out=%b credit=%0d lost=%0d catchup=%b expected 0/4/5/0",
                         i, bus.cen_out, bus.credit, bus.lost, bus.catchup);
            end
        end
        // Resume cycle only leaves PAUSED; replays start one cycle later.
        mask = '0;
        mask[1] = 1'b1; mask[4] = 1'b1; mask[7] = 1'b1; mask[10] = 1'b1;
        mask[15] = 1'b1; mask[22] = 1'b1;
        bus.pause = 1'b0;
        for (int j = 0; j < 25; j++) begin
            bus.cen_in = (j == 15) || (j == 22);
            tick();
            n_vec++;
            if (bus.cen_out !== mask[j]) begin
                n_err++;
                $display("FAIL resume cyc %0d: cen_out=%b expected %b", j, bus.cen_out, mask[j]);
            end
            if (j == 0) begin
                n_vec++;
                if (bus.catchup !== 1'b1 || bus.credit !== 4'd4) begin
                    n_err++;
                    $display("FAIL resume_state: catchup=%b credit=%0d expected 1/4", bus.catchup, bus.credit);
                end
            end
        end
        bus.cen_in = 1'b0;
        n_vec++;
        if (bus.credit !== 4'd0 || bus.catchup !== 1'b0) begin
            n_err++;
            $display("FAIL resume_drain: credit=%0d catchup=%b expected 0/0", bus.credit, bus.catchup);
        end
    endtask

    task automatic test_close_strobes();
        logic [9:0] mask;
        tick();
        tick();
        tick();
        mask = '0;
        mask[0] = 1'b1;
        mask[3] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bus.cen_in = (j == 0) || (j == 2);
            tick();
            n_vec++;
            if (bus.cen_out !== mask[j]) begin
                n_err++;
                $display("FAIL close cyc %0d: cen_out=%b expected %b", j, bus.cen_out, mask[j]);
            end
            if (j == 2) begin
                n_vec++;
                if (bus.credit !== 4'd1 || bus.catchup !== 1'b1) begin
                    n_err++;
                    $display("FAIL close_bank: credit=%0d catchup=%b expected 1/1", bus.credit, bus.catchup);
                end
            end
            if (j == 3) begin
                n_vec++;
                if (bus.credit !== 4'd0 || bus.catchup !== 1'b0) begin
                    n_err++;
                    $display("FAIL close_drain: credit=%0d catchup=%b expected 0/0", bus.credit, bus.catchup);
                end
            end
        end
        bus.cen_in = 1'b0;
    endtask

    task automatic test_mid_reset();
        bus.stall = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.cen_in = (i % 2 == 0);
            tick();
        end
        bus.cen_in = 1'b0;
        n_vec++;
        if (bus.credit !== 4'd6 || bus.catchup !== 1'b1) begin
            n_err++;
            $display("FAIL rst_setup: credit=%0d catchup=%b expected 6/1", bus.credit, bus.catchup);
        end
        bus.stall = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (bus.cen_out !== 1'b0 || bus.credit !== 4'd0 || bus.catchup !== 1'b0 || bus.lost !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid: cen_out=%b credit=%0d catchup=%b lost=%0d expected 0/0/0/0",
                     bus.cen_out, bus.credit, bus.catchup, bus.lost);
        end
        for (int j = 0; j < 20; j++) begin
            tick();
            n_vec++;
            if (bus.cen_out !== 1'b0 || bus.credit !== 4'd0) begin
                n_err++;
                $display("FAIL rst_quiet cyc %0d: cen_out=%b credit=%0d expected 0/0",
                         j, bus.cen_out, bus.credit);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pulse_cnt = 0;
        reset = 1'b1;
        bus.cen_in = 1'b0;
        bus.stall = 1'b0;
        bus.pause = 1'b0;
        test_reset();
        test_pass_through();
        test_stall_replay();
        test_saturation();
        test_pause();
        test_close_strobes();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snowbro2_cen_ctrl.md
# snowbro2_cen_ctrl

Clock-enable recovery controller between a fractional clock-enable source (e.g. the 6.75 MHz or 3.375 MHz strobe off the 94.5 MHz domain) and one consumer (Z80 sound CPU, OKI, YM). Raw strobes arriving while the consumer is stalled on SDRAM, or too close to the previous output strobe, are banked as credits. Banked credits are replayed later at a bounded rate, so the consumer's long-run strobe count matches the source. A pause input freezes the consumer without losing banked time.

## Interface
- CW, default 4: credit counter width; maximum bank is 2^CW-1.
- GAP, default 3, legal 1..15: minimum spacing, in CLK cycles, between consecutive CEN_OUT pulses.
- CLK  in  1  domain clock (94.5 MHz); all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CEN_IN  in  1  raw single-cycle enable strobe from the fractional divider.
- STALL  in  1  consumer is waiting on memory; no strobe may be delivered.
- PAUSE  in  1  freeze request (OSD/debug); level-sensitive.
- CEN_OUT  out  1  registered single-cycle enable to the consumer.
- CREDIT  out  CW  current banked strobe count.
- CATCHUP  out  1  high while state is CATCHUP.
- LOST  out  8  saturating count of strobes dropped because the bank was full.

## Operation
- States:
  - RUN: credit == 0, not paused.
  - CATCHUP: credit > 0, not paused.
  - PAUSED.
- eligible: cycles since the last CEN_OUT pulse >= GAP. The spacing counter saturates at GAP and is GAP after reset.
- RUN/CATCHUP, each cycle, in priority order:
  - PAUSE=1: next state PAUSED. No CEN_OUT. CEN_IN on this cycle is discarded, and credit does not change.
  - STALL=1 or !eligible:
    - CEN_IN=1 with credit < max: credit += 1.
    - CEN_IN=1 with credit == max: LOST += 1, saturating at 255.
  - Otherwise, with CEN_IN=1: CEN_OUT=1 next cycle; credit unchanged.
  - Otherwise, with CEN_IN=0 and credit > 0: CEN_OUT=1 next cycle; credit -= 1.
  - Otherwise: idle.
  - Next state (when not PAUSED): CATCHUP if the resulting credit > 0, else RUN.
- PAUSED:
  - CEN_OUT held 0. CEN_IN is ignored; no accrual and no LOST increment.
  - Credit is preserved.
  - The spacing counter keeps counting.
  - PAUSE=0: next state is CATCHUP if credit > 0, else RUN. Normal processing resumes the cycle after the state changes.
- STALL has no effect while PAUSED.
- CREDIT, CATCHUP and LOST are registered and reflect the state after the update.
- Arithmetic: credit never wraps; LOST never wraps.

## Timing
- Reset values: CEN_OUT=0, CREDIT=0, CATCHUP=0, LOST=0, state RUN, spacing counter=GAP.
- RESET asserted mid-catch-up discards all credits on the next edge.
- Latency: a CEN_IN accepted at cycle t gives CEN_OUT high during cycle t+1 only.
- Spacing: CEN_OUT pulses at t and t' require t' - t >= GAP. With GAP=1, back-to-back pulses are allowed.
- Source strobe and replay in the same cycle: the live strobe is delivered and the replay waits. Credit is never consumed on a cycle that carries CEN_IN.
- STALL is sampled in the same cycle as CEN_IN. A STALL deasserting at cycle t allows delivery decided at t, so a pulse can appear at t+1.
- CEN_OUT is never high for two consecutive cycles when GAP >= 2.

## Test plan
- Reset, GAP=3, CEN_IN every 7 cycles, STALL=0:
  - CEN_OUT is an exact copy of CEN_IN delayed by 1 cycle.
  - CREDIT stays 0; CATCHUP stays 0.
- STALL held for 30 cycles (5 strobes), then released:
  - CREDIT reaches 5 and CATCHUP=1.
  - After release, 5 replay pulses appear spaced 3 cycles apart, interleaved with live strobes.
  - CREDIT returns to 0 and CATCHUP drops.
- CW=4, STALL held across 20 strobes:
  - CREDIT saturates at 15 and LOST=5.
  - Total CEN_OUT count after release is 15 plus the live strobes.
- PAUSE asserted with CREDIT=4, held for 100 cycles with strobes arriving:
  - CEN_OUT=0 throughout; CREDIT stays 4; LOST unchanged.
  - After PAUSE drops, 4 replays then normal pass-through.
- GAP=3, CEN_IN on two cycles 2 apart with credit 0:
  - The first strobe is delivered.
  - The second is banked (CREDIT=1) and replayed at the earliest eligible cycle, 3 after the first pulse.
- RESET pulsed while CREDIT=6 and CATCHUP=1:
  - Next cycle all outputs are 0, state is RUN, and no further replays occur.
